// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multi-cycle MIPS main control FSM.
// Moore decode of state plus FETCH handshake terms; memory states stall on mem_ready_i.
module mc_main_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       branch_ne_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_source_o,
  output logic [2:0] ALUOp_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB
  } state_t;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  state_t state, nxt, dec;
  logic [5:0] op_q;
  always_comb begin
    dec = FETCH;
    case (op_i)
      OP_LW, OP_SW: dec = MEM_ADDR;
      OP_R: dec = R_EXEC;
      OP_BEQ, OP_BNE: dec = BRANCH;
      OP_J: dec = JUMP;
      OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: dec = I_EXEC;
      default: dec = FETCH;
    endcase
    nxt = FETCH;
    case (state)
      FETCH: nxt = mem_ready_i ? DECODE : FETCH;
      DECODE: nxt = dec;
      MEM_ADDR: nxt = (op_q == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD: nxt = mem_ready_i ? MEM_WB : MEM_RD;
      MEM_WR: nxt = mem_ready_i ? FETCH : MEM_WR;
      R_EXEC: nxt = R_WB;
      I_EXEC: nxt = I_WB;
      default: nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= FETCH;
      op_q <= '0;
    end else begin
      state <= nxt;
      if (state == DECODE) op_q <= op_i;
    end
  end
  // Enables are gated by rst_i so nothing writes while reset is held.
  assign pc_write_o      = rst_i & ((state == FETCH & mem_ready_i) | state == JUMP);
  assign ir_write_o      = rst_i & state == FETCH & mem_ready_i;
  assign pc_write_cond_o = rst_i & state == BRANCH;
  assign mem_read_o      = rst_i & (state == FETCH | state == MEM_RD);
  assign mem_write_o     = rst_i & state == MEM_WR;
  assign reg_write_o     = rst_i & (state == MEM_WB | state == R_WB | state == I_WB);
  assign branch_ne_o     = state == BRANCH & op_q == OP_BNE;
  assign iord_o          = state == MEM_RD | state == MEM_WR;
  assign mem_to_reg_o    = state == MEM_WB;
  assign reg_dst_o       = state == R_WB;
  assign alu_src_a_o     = state == MEM_ADDR | state == R_EXEC | state == I_EXEC | state == BRANCH;
  assign alu_src_b_o     = state == DECODE ? 2'd3 :
                           (state == MEM_ADDR | state == I_EXEC) ? 2'd2 :
                           (state == R_EXEC | state == BRANCH) ? 2'd0 : 2'd1;
  assign pc_source_o     = state == BRANCH ? 2'd1 : state == JUMP ? 2'd2 : 2'd0;
  assign ALUOp_o         = state == R_EXEC ? 3'd2 :
                           state == BRANCH ? (op_q == OP_BNE ? 3'd7 : 3'd1) :
                           state == I_EXEC ? (op_q == OP_SLTI ? 3'd5 : op_q == OP_ORI ? 3'd0 :
                                              op_q == OP_LUI ? 3'd3 : 3'd4) : 3'd4;
  assign state_o         = state;
  assign illegal_o       = state == DECODE & dec == FETCH;
endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl: scoreboard bench; stimulus queues per-cycle expected outputs, monitor checks at negedge.
module tb_mc_main_ctrl;
  logic clk = 0, rst_i = 0, mem_ready_i = 0;
  logic [5:0] op_i = '0;
  logic pc_write_o, pc_write_cond_o, branch_ne_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
  logic mem_to_reg_o, reg_write_o, reg_dst_o, alu_src_a_o, illegal_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [2:0] ALUOp_o;
  logic [3:0] state_o;
  logic [22:0] outs;
  int checks = 0, failures = 0;
  typedef struct { logic [22:0] e; string tag; } item_t;
  item_t sb[$];
  localparam logic [11:0] PW = 12'h800, PWC = 12'h400, BNE = 12'h200, IORD = 12'h100,
                          MR = 12'h080, MW = 12'h040, IRW = 12'h020, M2R = 12'h010,
                          RW = 12'h008, RDST = 12'h004, SRCA = 12'h002, ILL = 12'h001, NONE = 12'h000;
  mc_main_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .branch_ne_o(branch_ne_o),
    .iord_o(iord_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .pc_source_o(pc_source_o),
    .ALUOp_o(ALUOp_o), .state_o(state_o), .illegal_o(illegal_o)
  );
  always #5 clk = ~clk;
  assign outs = {state_o, ALUOp_o, alu_src_b_o, pc_source_o, pc_write_o, pc_write_cond_o,
                 branch_ne_o, iord_o, mem_read_o, mem_write_o, ir_write_o, mem_to_reg_o,
                 reg_write_o, reg_dst_o, alu_src_a_o, illegal_o};
  function automatic logic [22:0] mk(int st, int aop, int sb_v, int ps, logic [11:0] en);
    logic [3:0] s = st[3:0];
    logic [2:0] a = aop[2:0];
    logic [1:0] b = sb_v[1:0];
    logic [1:0] p = ps[1:0];
    return {s, a, b, p, en};
  endfunction
  task automatic cmp(input string tag, input logic [22:0] got, input logic [22:0] e);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s got=%h (st=%0d aop=%0d) exp=%h (st=%0d aop=%0d)",
               tag, got, got[22:19], got[18:16], e, e[22:19], e[18:16]);
    end
  endtask
  task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                      input logic [22:0] e, input string tag);
    item_t it;
    @(posedge clk);
    #1;
    rst_i = r;
    op_i = op;
    mem_ready_i = rdy;
    it.e = e;
    it.tag = tag;
    sb.push_back(it);
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      cmp(it.tag, outs, it.e);
    end
  end
  logic [22:0] r0, f_rdy, f_wait, d, r_ex;
  initial begin
    r0 = mk(0, 4, 1, 0, NONE);
    f_rdy = mk(0, 4, 1, 0, MR | PW | IRW);
    f_wait = mk(0, 4, 1, 0, MR);
    d = mk(1, 4, 3, 0, NONE);
    r_ex = mk(6, 2, 0, 0, SRCA);
    step(1'b0, 6'h00, 1'b1, r0, "reset_hold");
    step(1'b1, 6'h00, 1'b1, f_rdy, "add_fetch");
    step(1'b1, 6'h00, 1'b0, d, "add_decode");
    step(1'b1, 6'h3F, 1'b1, r_ex, "add_rexec");
    step(1'b1, 6'h00, 1'b1, mk(7, 4, 1, 0, RW | RDST), "add_rwb");
    step(1'b1, 6'h23, 1'b1, f_rdy, "lw_fetch");
    step(1'b1, 6'h23, 1'b1, d, "lw_decode");
    step(1'b1, 6'h23, 1'b1, mk(2, 4, 2, 0, SRCA), "lw_addr");
    step(1'b1, 6'h23, 1'b0, mk(3, 4, 1, 0, MR | IORD), "lw_rd_wait1");
    step(1'b1, 6'h23, 1'b0, mk(3, 4, 1, 0, MR | IORD), "lw_rd_wait2");
    step(1'b1, 6'h23, 1'b1, mk(3, 4, 1, 0, MR | IORD), "lw_rd_done");
    step(1'b1, 6'h00, 1'b0, mk(4, 4, 1, 0, RW | M2R), "lw_wb");
    step(1'b1, 6'h05, 1'b1, f_rdy, "bne_fetch");
    step(1'b1, 6'h05, 1'b1, d, "bne_decode");
    step(1'b1, 6'h04, 1'b1, mk(8, 7, 0, 1, PWC | BNE | SRCA), "bne_branch");
    step(1'b1, 6'h04, 1'b1, f_rdy, "beq_fetch");
    step(1'b1, 6'h04, 1'b1, d, "beq_decode");
    step(1'b1, 6'h05, 1'b1, mk(8, 1, 0, 1, PWC | SRCA), "beq_branch");
    step(1'b1, 6'h0D, 1'b1, f_rdy, "ori_fetch");
    step(1'b1, 6'h0D, 1'b1, d, "ori_decode");
    step(1'b1, 6'h23, 1'b1, mk(10, 0, 2, 0, SRCA), "ori_iexec");
    step(1'b1, 6'h23, 1'b1, mk(11, 4, 1, 0, RW), "ori_iwb");
    step(1'b1, 6'h0A, 1'b1, f_rdy, "slti_fetch");
    step(1'b1, 6'h0A, 1'b1, d, "slti_decode");
    step(1'b1, 6'h0A, 1'b1, mk(10, 5, 2, 0, SRCA), "slti_iexec");
    step(1'b1, 6'h0A, 1'b1, mk(11, 4, 1, 0, RW), "slti_iwb");
    step(1'b1, 6'h0F, 1'b1, f_rdy, "lui_fetch");
    step(1'b1, 6'h0F, 1'b1, d, "lui_decode");
    step(1'b1, 6'h0F, 1'b1, mk(10, 3, 2, 0, SRCA), "lui_iexec");
    step(1'b1, 6'h0F, 1'b1, mk(11, 4, 1, 0, RW), "lui_iwb");
    step(1'b1, 6'h08, 1'b1, f_rdy, "addi_fetch");
    step(1'b1, 6'h08, 1'b1, d, "addi_decode");
    step(1'b1, 6'h08, 1'b1, mk(10, 4, 2, 0, SRCA), "addi_iexec");
    step(1'b1, 6'h08, 1'b1, mk(11, 4, 1, 0, RW), "addi_iwb");
    step(1'b1, 6'h02, 1'b1, f_rdy, "j_fetch");
    step(1'b1, 6'h02, 1'b1, d, "j_decode");
    step(1'b1, 6'h02, 1'b0, mk(9, 4, 1, 2, PW), "j_jump");
    step(1'b1, 6'h2B, 1'b1, f_rdy, "sw_fetch");
    step(1'b1, 6'h2B, 1'b1, d, "sw_decode");
    step(1'b1, 6'h2B, 1'b1, mk(2, 4, 2, 0, SRCA), "sw_addr");
    step(1'b1, 6'h2B, 1'b0, mk(5, 4, 1, 0, MW | IORD), "sw_wr_wait");
    step(1'b1, 6'h2B, 1'b1, mk(5, 4, 1, 0, MW | IORD), "sw_wr_done");
    step(1'b1, 6'h3F, 1'b0, f_wait, "ill_fetch_stall1");
    step(1'b1, 6'h3F, 1'b0, f_wait, "ill_fetch_stall2");
    step(1'b1, 6'h3F, 1'b0, f_wait, "ill_fetch_stall3");
    step(1'b1, 6'h3F, 1'b1, f_rdy, "ill_fetch");
    step(1'b1, 6'h3F, 1'b1, mk(1, 4, 3, 0, ILL), "ill_decode");
    step(1'b1, 6'h00, 1'b1, f_rdy, "rst_fetch");
    step(1'b1, 6'h00, 1'b1, d, "rst_decode");
    step(1'b1, 6'h00, 1'b1, r_ex, "rst_rexec");
    @(negedge clk);
    #2;
    rst_i = 0;
    #1;
    cmp("async_rst_same_cycle", outs, r0);
    step(1'b0, 6'h00, 1'b1, r0, "rst_held");
    step(1'b1, 6'h00, 1'b0, f_wait, "post_rst_fetch");
    step(1'b1, 6'h00, 1'b1, f_rdy, "post_rst_fetch_rdy");
    step(1'b1, 6'h00, 1'b1, d, "post_rst_decode");
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_main_ctrl.md
# mc_main_ctrl

Multi-cycle main control FSM for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables and muxes. Produces the 3-bit `ALUOp_o` consumed by the ALU control stage alongside `funct`. Memory accesses use a ready handshake, so variable-latency memory stalls the sequence.

## Interface
- No parameters.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous reset, active-low.
- `op_i` in 6: opcode field IR[31:26].
- `mem_ready_i` in 1: memory completes the current read or write this cycle.
- `pc_write_o` out 1: unconditional PC write.
- `pc_write_cond_o` out 1: PC write qualified by the ALU zero flag.
- `branch_ne_o` out 1: 1 = use the inverted zero flag (bne).
- `iord_o` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read_o` out 1: memory read.
- `mem_write_o` out 1: memory write.
- `ir_write_o` out 1: IR load.
- `mem_to_reg_o` out 1: writeback select; 1 = MDR, 0 = ALUOut.
- `reg_write_o` out 1: register file write.
- `reg_dst_o` out 1: destination register; 1 = rd, 0 = rt.
- `alu_src_a_o` out 1: ALU A operand; 0 = PC, 1 = A register.
- `alu_src_b_o` out 2: ALU B operand; 0 = B register, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- `pc_source_o` out 2: PC source; 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `ALUOp_o` out 3: ALU operation class for the ALU control stage.
- `state_o` out 4: current state (debug).
- `illegal_o` out 1: unknown opcode seen in DECODE.

## Operation
- State codes:
  - 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_RD, 4 MEM_WB, 5 MEM_WR
  - 6 R_EXEC, 7 R_WB, 8 BRANCH, 9 JUMP, 10 I_EXEC, 11 I_WB
  - Codes 12–15 are unreachable; if entered, next state is FETCH.
- Opcodes: R 0x00, j 0x02, beq 0x04, bne 0x05, addi 0x08, slti 0x0A, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B.
- `ALUOp_o` codes: 2 R-type (funct decides), 4 add, 1 sub/beq, 5 slti, 3 lui, 0 ori, 7 bne.
- Opcode latch: `op_q` is captured from `op_i` on the DECODE→next edge. All later states use `op_q`.
- Moore outputs decoded from state. All outputs default to 0 except `ALUOp_o`=4 and `alu_src_b_o`=1.
- State actions:
  - **FETCH:** `mem_read`=1, `iord`=0, `src_a`=0, `src_b`=1, `ALUOp`=4, `pc_source`=0.
    - `pc_write_o` and `ir_write_o` equal `mem_ready_i` (the only Mealy terms).
    - Go to DECODE when `mem_ready_i` is high; otherwise stay.
  - **DECODE:** `src_a`=0, `src_b`=3, `ALUOp`=4.
    - Next state: lw/sw → MEM_ADDR, R → R_EXEC, beq/bne → BRANCH, j → JUMP, addi/slti/ori/lui → I_EXEC.
    - Any other opcode: `illegal_o`=1 this cycle, next FETCH.
  - **MEM_ADDR:** `src_a`=1, `src_b`=2, `ALUOp`=4. Next MEM_RD (lw) or MEM_WR (sw).
  - **MEM_RD:** `mem_read`=1, `iord`=1. Hold until `mem_ready_i`, then MEM_WB.
  - **MEM_WB:** `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Next FETCH.
  - **MEM_WR:** `mem_write`=1, `iord`=1. Hold until `mem_ready_i`, then FETCH.
  - **R_EXEC:** `src_a`=1, `src_b`=0, `ALUOp`=2. Next R_WB.
  - **R_WB:** `reg_write`=1, `reg_dst`=1. Next FETCH.
  - **I_EXEC:** `src_a`=1, `src_b`=2, `ALUOp`= 4 / 5 / 0 / 3 for addi / slti / ori / lui. Next I_WB.
  - **I_WB:** `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next FETCH.
  - **BRANCH:** `src_a`=1, `src_b`=0, `pc_write_cond`=1, `pc_source`=1.
    - `ALUOp`=1 and `branch_ne`=0 for beq; `ALUOp`=7 and `branch_ne`=1 for bne.
    - Next FETCH.
  - **JUMP:** `pc_write`=1, `pc_source`=2. Next FETCH.

## Timing
- **Reset:**
  - `rst_i`=0 immediately forces state to FETCH and `op_q` to 0, independent of the clock.
  - While `rst_i`=0, `pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write` and `reg_write` are forced to 0.
  - Reset output values: `state_o`=0, `ALUOp_o`=4, `alu_src_b_o`=1, all others 0.
  - The first fetch begins in the cycle after `rst_i` rises.
- **Reset mid-instruction:** the instruction is abandoned, with no register or memory write after assertion.
- **Cycle counts with zero wait** (`mem_ready_i`=1 in the request cycle):
  - R, I and sw take 4 cycles; lw takes 5.
  - beq, bne and j take 3.
  - Illegal opcodes take 2.
- **Memory waits:** each cycle with `mem_ready_i`=0 in FETCH, MEM_RD or MEM_WR adds one cycle. All outputs stay constant during waits.
- **Ignored inputs:** `mem_ready_i` is ignored in every other state. `op_i` changes after DECODE have no effect.

## Test plan
- Reset mid-R_EXEC (`rst_i` low asynchronously) → same-cycle `state_o`=0, all enables 0, `ALUOp_o`=4. After release, FETCH with `mem_read_o`=1.
- add (op 0x00) with `mem_ready_i`=1 → states 0,1,6,7,0. `ALUOp_o`=2 in state 6. `reg_write_o`=`reg_dst_o`=1 only in state 7.
- lw (0x23) with `mem_ready_i` low for 2 cycles in MEM_RD → states 0,1,2,3,3,3,4,0. `iord_o`=1 throughout MEM_RD. `mem_to_reg_o`=1 in state 4.
- bne (0x05), then beq (0x04) → state 8 with `ALUOp_o`=7, `branch_ne_o`=1, then `ALUOp_o`=1, `branch_ne_o`=0. `pc_write_cond_o`=1 and `pc_source_o`=1 in both.
- ori (0x0D), with `op_i` changed to 0x23 during I_EXEC → `ALUOp_o`=0 in state 10, then I_WB with `reg_dst_o`=0.
- Opcode 0x3F → `illegal_o`=1 in DECODE only, next state 0, no enable asserted. FETCH stall (`mem_ready_i`=0 for 3 cycles) keeps `pc_write_o`=`ir_write_o`=0 until ready.
